imem_boot_arbiter: RTL and testbench

//  Owns the single port of the 1024x32 instruction memory (combinational read, synchronous write).

---
 rtl/imem_boot_arbiter_pkg.sv | 26 ++
 rtl/imem_boot_arbiter_if.sv | 53 +++++
 rtl/imem_boot_arbiter.sv | 142 ++++++++++++++
 tb/tb_imem_boot_arbiter.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/imem_boot_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// imem_boot_arbiter_pkg
//   Shared constants and types for the instruction-memory boot arbiter:
//   memory geometry, the NOP returned to a stalled core, and the FSM state
//   encoding.
// -----------------------------------------------------------------------------
package imem_boot_arbiter_pkg;

    localparam int DEPTH  = 1024;
    localparam int ADDR_W = $clog2(DEPTH);

    // Last word address of the memory; a boot stream that reaches it without
    // ld_last has overrun the memory.
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    // addi x0,x0,0
    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2,
        DBGW = 2'd3
    } state_e;

endpackage : imem_boot_arbiter_pkg

// File: rtl/imem_boot_arbiter_if.sv
// -----------------------------------------------------------------------------
// imem_boot_arbiter_if
//   Bundles every non-clock/reset signal of the arbiter.
//   Ports (arbiter view, modport slave):
//     boot stream : ld_valid/ld_data/ld_last in, ld_ready out
//     core fetch  : fetch_addr in, fetch_data/core_stall/core_rst_n/misalign out
//     debug write : dbg_req/dbg_addr/dbg_wdata in, dbg_ack out
//     memory port : mem_rdata in, mem_addr/mem_wdata/mem_we out
//     status      : load_err out
//   The master modport is the environment side (boot source, core, debugger
//   and memory instance).
// -----------------------------------------------------------------------------
interface imem_boot_arbiter_if;
    import imem_boot_arbiter_pkg::*;

    logic              ld_valid;
    logic [31:0]       ld_data;
    logic              ld_last;
    logic              ld_ready;

    logic [31:0]       fetch_addr;
    logic [31:0]       fetch_data;
    logic              core_stall;
    logic              core_rst_n;

    logic              dbg_req;
    logic [ADDR_W-1:0] dbg_addr;
    logic [31:0]       dbg_wdata;
    logic              dbg_ack;

    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic              mem_we;
    logic [31:0]       mem_rdata;

    logic              load_err;
    logic              misalign;

    modport slave (
        input  ld_valid, ld_data, ld_last, fetch_addr,
               dbg_req, dbg_addr, dbg_wdata, mem_rdata,
        output ld_ready, fetch_data, core_stall, core_rst_n,
               dbg_ack, mem_addr, mem_wdata, mem_we, load_err, misalign
    );

    modport master (
        output ld_valid, ld_data, ld_last, fetch_addr,
               dbg_req, dbg_addr, dbg_wdata, mem_rdata,
        input  ld_ready, fetch_data, core_stall, core_rst_n,
               dbg_ack, mem_addr, mem_wdata, mem_we, load_err, misalign
    );

endinterface : imem_boot_arbiter_if

// File: rtl/imem_boot_arbiter.sv
// -----------------------------------------------------------------------------
// imem_boot_arbiter
//   Owns the single port of a 1024x32 instruction memory (combinational read,
//   synchronous write). After reset it accepts a boot word stream written from
//   address 0 upward while the core is held in reset, then releases the core
//   and arbitrates each cycle between core fetch and single-cycle debug writes.
//   Ports:
//     clk  - system clock, rising edge
//     rst  - asynchronous reset, active low
//     bus  - imem_boot_arbiter_if.slave (boot stream, core fetch, debug write,
//            memory port, status flags)
// -----------------------------------------------------------------------------
module imem_boot_arbiter
    import imem_boot_arbiter_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    imem_boot_arbiter_if.slave bus
);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] load_cnt_q, load_cnt_d;
    logic              load_err_q, load_err_d;
    logic              dbg_ack_q, dbg_ack_d;
    logic              core_rst_n_q, core_rst_n_d;

    logic              ld_ready;
    logic              ld_hs;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic              mem_we;
    logic [31:0]       fetch_data;
    logic              core_stall;

    // Fetch address bits above the memory window are dropped (address wrap).
    logic              unused_fetch_hi;
    assign unused_fetch_hi = ^bus.fetch_addr[31:ADDR_W+2];

    // NOTE: the state register is already IDLE while rst is low, so the only
    // output that needs explicit gating is ld_ready, which must read 0 during
    // reset even though IDLE otherwise accepts words.
    assign ld_ready = rst && ((state_q == IDLE) || (state_q == LOAD));
    assign ld_hs    = bus.ld_valid && ld_ready;

    // NOTE: every signal written in this block gets a default first, so no
    // path through the case statement can leave one unassigned and infer a latch.
    always_comb begin
        state_d    = state_q;
        load_cnt_d = load_cnt_q;
        load_err_d = load_err_q;
        mem_addr   = '0;
        mem_wdata  = '0;
        mem_we     = 1'b0;
        fetch_data = NOP;
        core_stall = 1'b1;

        unique case (state_q)
            IDLE: begin
                mem_wdata = bus.ld_data;
                mem_we    = ld_hs;
                if (ld_hs) begin
                    load_cnt_d = ADDR_W'(1);
                    state_d    = bus.ld_last ? RUN : LOAD;
                end
            end

            LOAD: begin
                mem_addr  = load_cnt_q;
                mem_wdata = bus.ld_data;
                mem_we    = ld_hs;
                if (ld_hs) begin
                    load_cnt_d = load_cnt_q + 1'b1;
                    if (bus.ld_last) begin
                        state_d = RUN;
                    end else if (load_cnt_q == LAST_ADDR) begin
                        // Memory is full but the stream has not ended.
                        state_d    = RUN;
                        load_err_d = 1'b1;
                    end
                end
            end

            RUN: begin
                mem_addr   = bus.fetch_addr[ADDR_W+1:2];
                fetch_data = bus.mem_rdata;
                core_stall = 1'b0;
                // A request still held in the acknowledge cycle belongs to
                // the write that just committed; do not grant it again.
                if (bus.dbg_req && !dbg_ack_q) begin
                    state_d = DBGW;
                end
            end

            DBGW: begin
                mem_addr  = bus.dbg_addr;
                mem_wdata = bus.dbg_wdata;
                mem_we    = 1'b1;
                state_d   = RUN;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign dbg_ack_d    = (state_q == DBGW);
    // Core reset is released on entry to RUN and stays released until reset.
    assign core_rst_n_d = core_rst_n_q || (state_d == RUN);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            load_cnt_q   <= '0;
            load_err_q   <= 1'b0;
            dbg_ack_q    <= 1'b0;
            core_rst_n_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            load_cnt_q   <= load_cnt_d;
            load_err_q   <= load_err_d;
            dbg_ack_q    <= dbg_ack_d;
            core_rst_n_q <= core_rst_n_d;
        end
    end

    // NOTE: the memory array lives outside this block and is deliberately not
    // touched by reset; its contents survive an aborted load or debug write.
    assign bus.mem_addr   = mem_addr;
    assign bus.mem_wdata  = mem_wdata;
    assign bus.mem_we     = mem_we;
    assign bus.ld_ready   = ld_ready;
    assign bus.fetch_data = fetch_data;
    assign bus.core_stall = core_stall;
    assign bus.core_rst_n = core_rst_n_q;
    assign bus.dbg_ack    = dbg_ack_q;
    assign bus.load_err   = load_err_q;
    assign bus.misalign   = (state_q == RUN) && (bus.fetch_addr[1:0] != 2'b00);

endmodule : imem_boot_arbiter

// File: tb/tb_imem_boot_arbiter.sv
// -----------------------------------------------------------------------------
// tb_imem_boot_arbiter
//   Self-checking bench for imem_boot_arbiter. Drives inputs just after the
//   falling edge and samples 1 ns later; the rising edge is the active edge.
//   A behavioural memory image (ref_mem) holds what the instruction memory
//   must contain; expectations come from it and from the arbiter's rules.
// -----------------------------------------------------------------------------
module tb_imem_boot_arbiter;
    import imem_boot_arbiter_pkg::*;

    localparam logic [31:0] EXP_NOP = 32'h0000_0013;
    // Held debug request starting in a plain RUN cycle: grants in cycles 1 and
    // 4 (cycle 2 is the ignored acknowledge cycle, cycle 3 re-arbitrates).
    localparam logic [5:0]  B2B_WE  = 6'b010010;
    localparam logic [5:0]  B2B_ACK = 6'b100100;

    logic              clk;
    logic              rst;
    int                n_checks;
    int                n_fail;
    logic [31:0]       mem     [DEPTH];
    logic [31:0]       ref_mem [DEPTH];
    logic [ADDR_W-1:0] t_addr;
    logic [31:0]       t_data;

    imem_boot_arbiter_if bus_if ();

    imem_boot_arbiter dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Instruction memory instance: combinational read, synchronous write.
    assign bus_if.mem_rdata = mem[bus_if.mem_addr];
    always @(posedge clk) begin
        if (bus_if.mem_we) mem[bus_if.mem_addr] <= bus_if.mem_wdata;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic int unsigned word_of(input logic [31:0] byte_addr);
        int unsigned a;
        a = byte_addr;
        return (a / 4) % DEPTH;
    endfunction

    task automatic drive_idle();
        bus_if.ld_valid   = 1'b0;
        bus_if.ld_data    = '0;
        bus_if.ld_last    = 1'b0;
        bus_if.fetch_addr = '0;
        bus_if.dbg_req    = 1'b0;
        bus_if.dbg_addr   = '0;
        bus_if.dbg_wdata  = '0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_ld_ready"},   bus_if.ld_ready,   0);
        check({tag, "_core_rst_n"}, bus_if.core_rst_n, 0);
        check({tag, "_core_stall"}, bus_if.core_stall, 1);
        check({tag, "_dbg_ack"},    bus_if.dbg_ack,    0);
        check({tag, "_mem_we"},     bus_if.mem_we,     0);
        check({tag, "_load_err"},   bus_if.load_err,   0);
        check({tag, "_fetch_data"}, bus_if.fetch_data, EXP_NOP);
    endtask

    // Reset asserted on a falling edge while a boot word is offered.
    task automatic reset_and_check(input string tag);
        @(negedge clk);
        rst               = 1'b0;
        bus_if.ld_valid   = 1'b1;
        bus_if.ld_data    = $urandom;
        #1;
        check_reset_outputs(tag);
        @(negedge clk);
        #1;
        check({tag, "_held_ld_ready"}, bus_if.ld_ready, 0);
        drive_idle();
        rst = 1'b1;
    endtask

    task automatic load_word(input int idx, input logic [31:0] data, input logic last);
        if ($urandom_range(3) == 0) begin
            @(negedge clk);
            drive_idle();
            #1;
            check("load_gap_we",    bus_if.mem_we,   0);
            check("load_gap_ready", bus_if.ld_ready, 1);
        end
        @(negedge clk);
        drive_idle();
        bus_if.ld_valid = 1'b1;
        bus_if.ld_data  = data;
        bus_if.ld_last  = last;
        #1;
        check("load_ready",      bus_if.ld_ready,   1);
        check("load_we",         bus_if.mem_we,     1);
        check("load_addr",       bus_if.mem_addr,   idx);
        check("load_wdata",      bus_if.mem_wdata,  data);
        check("load_core_rst_n", bus_if.core_rst_n, 0);
        check("load_stall",      bus_if.core_stall, 1);
        check("load_fetch_nop",  bus_if.fetch_data, EXP_NOP);
        ref_mem[idx] = data;
    endtask

    task automatic finish_load(input logic exp_err);
        @(negedge clk);
        drive_idle();
        #1;
        check("run_core_rst_n", bus_if.core_rst_n, 1);
        check("run_stall",      bus_if.core_stall, 0);
        check("run_ld_ready",   bus_if.ld_ready,   0);
        check("run_load_err",   bus_if.load_err,   exp_err);
    endtask

    task automatic fetch_check(input logic [31:0] addr);
        @(negedge clk);
        drive_idle();
        bus_if.fetch_addr = addr;
        #1;
        check("fetch_data",     bus_if.fetch_data, ref_mem[word_of(addr)]);
        check("fetch_stall",    bus_if.core_stall, 0);
        check("fetch_we",       bus_if.mem_we,     0);
        check("fetch_misalign", bus_if.misalign,   (addr % 4) != 0);
    endtask

    task automatic dbg_write(input logic [ADDR_W-1:0] addr, input logic [31:0] data);
        logic [31:0] fa;
        fa = $urandom;
        // Request cycle: arbiter is still in RUN and serves the fetch.
        @(negedge clk);
        drive_idle();
        bus_if.dbg_req    = 1'b1;
        bus_if.dbg_addr   = addr;
        bus_if.dbg_wdata  = data;
        bus_if.fetch_addr = fa;
        #1;
        check("dbg_req_stall", bus_if.core_stall, 0);
        check("dbg_req_we",    bus_if.mem_we,     0);
        check("dbg_req_fetch", bus_if.fetch_data, ref_mem[word_of(fa)]);
        // Grant cycle.
        @(negedge clk);
        #1;
        check("dbg_grant_we",       bus_if.mem_we,     1);
        check("dbg_grant_addr",     bus_if.mem_addr,   addr);
        check("dbg_grant_wdata",    bus_if.mem_wdata,  data);
        check("dbg_grant_stall",    bus_if.core_stall, 1);
        check("dbg_grant_nop",      bus_if.fetch_data, EXP_NOP);
        check("dbg_grant_misalign", bus_if.misalign,   0);
        check("dbg_grant_ack",      bus_if.dbg_ack,    0);
        ref_mem[addr] = data;
        // Acknowledge cycle with the request still held: no second grant.
        @(negedge clk);
        #1;
        check("dbg_ack",       bus_if.dbg_ack,    1);
        check("dbg_ack_we",    bus_if.mem_we,     0);
        check("dbg_ack_stall", bus_if.core_stall, 0);
        check("dbg_ack_fetch", bus_if.fetch_data, ref_mem[word_of(fa)]);
        bus_if.dbg_req = 1'b0;
        @(negedge clk);
        #1;
        check("dbg_ack_pulse", bus_if.dbg_ack, 0);
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst      = 1'b0;
        drive_idle();

        // Power-on reset values.
        #1;
        check_reset_outputs("por");
        repeat (2) @(negedge clk);
        rst = 1'b1;

        // Overrunning stream: 1024 words without ld_last fills the memory.
        for (int i = 0; i < DEPTH; i++) load_word(i, $urandom, 1'b0);
        @(negedge clk);
        drive_idle();
        bus_if.ld_valid = 1'b1;
        bus_if.ld_data  = $urandom;
        #1;
        check("over_ready",      bus_if.ld_ready,   0);
        check("over_we",         bus_if.mem_we,     0);
        check("over_err",        bus_if.load_err,   1);
        check("over_core_rst_n", bus_if.core_rst_n, 1);
        check("over_stall",      bus_if.core_stall, 0);
        for (int i = 0; i < 40; i++) fetch_check($urandom);
        fetch_check(32'(LAST_ADDR) << 2);

        // Normal three-word boot; reset also clears the sticky load_err.
        reset_and_check("rst_after_over");
        load_word(0, 32'h0000_000A, 1'b0);
        load_word(1, 32'h0000_000B, 1'b0);
        load_word(2, 32'h0000_000C, 1'b1);
        finish_load(1'b0);
        fetch_check(32'h0);
        fetch_check(32'h4);
        fetch_check(32'h8);
        check("fetch8_const", bus_if.fetch_data, 32'h0000_000C);

        // Debug write to word 5.
        dbg_write(ADDR_W'(5), 32'h0064_A423);
        fetch_check(32'h14);
        check("dbg5_const", bus_if.fetch_data, 32'h0064_A423);

        // Misaligned fetch and address wrap.
        fetch_check(32'h6);
        check("misalign_const", bus_if.misalign, 1);
        fetch_check(32'h1000);
        check("wrap_const", bus_if.fetch_data, 32'h0000_000A);

        // Random mix of fetches and debug writes.
        for (int k = 0; k < 150; k++) begin
            if ($urandom_range(9) < 3) dbg_write(ADDR_W'($urandom), $urandom);
            else fetch_check($urandom);
        end

        // Debug request held continuously.
        t_addr = ADDR_W'($urandom);
        t_data = $urandom;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            drive_idle();
            bus_if.dbg_req    = 1'b1;
            bus_if.dbg_addr   = t_addr;
            bus_if.dbg_wdata  = t_data;
            bus_if.fetch_addr = 32'(t_addr) << 2;
            #1;
            check("b2b_we",    bus_if.mem_we,     B2B_WE[c]);
            check("b2b_ack",   bus_if.dbg_ack,    B2B_ACK[c]);
            check("b2b_stall", bus_if.core_stall, B2B_WE[c]);
            if (B2B_WE[c]) ref_mem[t_addr] = t_data;
        end
        @(negedge clk);
        drive_idle();
        #1;
        check("b2b_end_we",  bus_if.mem_we,  0);
        check("b2b_end_ack", bus_if.dbg_ack, 0);
        fetch_check(32'(t_addr) << 2);

        // Reset during the debug grant cycle: the write must not commit.
        t_addr = ADDR_W'($urandom_range(1, DEPTH - 1));
        t_data = ~ref_mem[t_addr];
        @(negedge clk);
        drive_idle();
        bus_if.dbg_req   = 1'b1;
        bus_if.dbg_addr  = t_addr;
        bus_if.dbg_wdata = t_data;
        @(negedge clk);
        #1;
        check("abort_dbg_grant", bus_if.mem_we, 1);
        rst = 1'b0;
        #1;
        check("abort_dbg_we",         bus_if.mem_we,     0);
        check("abort_dbg_stall",      bus_if.core_stall, 1);
        check("abort_dbg_nop",        bus_if.fetch_data, EXP_NOP);
        check("abort_dbg_core_rst_n", bus_if.core_rst_n, 0);
        check("abort_dbg_ld_ready",   bus_if.ld_ready,   0);
        @(negedge clk);
        #1;
        check("abort_dbg_ack", bus_if.dbg_ack, 0);
        drive_idle();
        rst = 1'b1;
        load_word(0, $urandom, 1'b1);
        finish_load(1'b0);
        fetch_check(32'(t_addr) << 2);

        // Reset in LOAD after seven words; the new stream restarts at 0.
        reset_and_check("rst_mid_run");
        for (int i = 0; i < 7; i++) load_word(i, $urandom, 1'b0);
        reset_and_check("rst_mid_load");
        for (int i = 0; i < 3; i++) load_word(i, $urandom, i == 2);
        finish_load(1'b0);
        for (int i = 0; i < 8; i++) fetch_check(32'(i) << 2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_imem_boot_arbiter
